// File: rtl/cnn_accel_pkg.sv
// Shared definitions for the CNN accelerator shell: sequencer states and error causes.
package cnn_accel_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_DRAIN,
        S_DONE
    } state_e;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_NUM     = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_OVF     = 2'd3;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered pointers; read data is the head entry (no bypass).
module sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          push_i,
    input  logic [DATA_WIDTH-1:0]         wdata_i,
    input  logic                          pop_i,
    output logic [DATA_WIDTH-1:0]         rdata_o,
    output logic                          full_o,
    output logic                          empty_o,
    output logic [$clog2(FIFO_DEPTH):0]   count_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = FIFO_DEPTH[AW:0];

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [AW:0]           count_q;
    logic                  wr_en, rd_en;

    // A full FIFO still accepts a push when the same cycle pops.
    assign rd_en   = pop_i && !empty_o;
    assign wr_en   = push_i && (!full_o || pop_i);
    assign full_o  = (count_q == DEPTH_C);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, rd_en};
        end
    end

endmodule

// File: rtl/cnn_accel_shell.sv
// Layer sequencer for a CNN engine: walks a descriptor table, collects final-layer
// results into a FIFO stream, and gates host RAM writes while a job runs.
module cnn_accel_shell
    import cnn_accel_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 11,
    parameter int MODE_WIDTH = 3,
    parameter int MAX_LAYERS = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int TIMEOUT    = 65535
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [$clog2(MAX_LAYERS):0]   num_layers,
    input  logic                          cfg_we,
    input  logic [$clog2(MAX_LAYERS)-1:0] cfg_idx,
    input  logic [MODE_WIDTH-1:0]         cfg_mode,
    input  logic [ADDR_WIDTH-1:0]         cfg_base,
    input  logic                          host_we,
    input  logic [ADDR_WIDTH-1:0]         host_addr,
    input  logic [DATA_WIDTH-1:0]         host_wdata,
    output logic                          mem_we,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic [DATA_WIDTH-1:0]         mem_wdata,
    output logic                          eng_start,
    output logic [MODE_WIDTH-1:0]         eng_mode,
    output logic [ADDR_WIDTH-1:0]         eng_base,
    input  logic                          eng_done,
    input  logic                          eng_res_valid,
    input  logic [DATA_WIDTH-1:0]         eng_res,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [DATA_WIDTH-1:0]         res_data,
    output logic                          busy,
    output logic                          done,
    output logic                          err,
    output logic [1:0]                    err_code
);

    localparam int IW = $clog2(MAX_LAYERS);
    localparam int NW = IW + 1;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam int FW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
    localparam logic [NW-1:0] MAX_N   = NW'(MAX_LAYERS);

    state_e                  state_q, state_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [NW-1:0]           num_q, num_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [1:0]              err_code_q, err_code_d;
    logic                    err_evt;
    logic                    eng_start_q;
    logic [MODE_WIDTH-1:0]   mode_q;
    logic [ADDR_WIDTH-1:0]   base_q;
    logic [MODE_WIDTH-1:0]   tbl_mode_q [MAX_LAYERS];
    logic [ADDR_WIDTH-1:0]   tbl_base_q [MAX_LAYERS];

    logic                    last_layer;
    logic                    fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [FW:0]             fifo_cnt;
    logic [DATA_WIDTH-1:0]   fifo_rdata;

    assign last_layer = ({1'b0, idx_q} == num_q - NW'(1));
    assign fifo_push  = (state_q == S_WAIT) && last_layer && eng_res_valid;
    assign fifo_pop   = res_valid && res_ready;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        num_d      = num_q;
        cnt_d      = cnt_q;
        err_code_d = err_code_q;
        err_evt    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (num_layers != '0 && num_layers <= MAX_N) begin
                        err_code_d = ERR_NONE;
                        idx_d      = '0;
                        num_d      = num_layers;
                        state_d    = S_LAUNCH;
                    end else begin
                        err_evt    = 1'b1;
                        err_code_d = ERR_NUM;
                    end
                end
            end
            S_LAUNCH: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // cnt_q counts completed WAIT cycles; the TIMEOUT-th cycle gives up.
                if (eng_done) begin
                    if (last_layer) begin
                        state_d = S_DRAIN;
                    end else begin
                        idx_d   = idx_q + IW'(1);
                        state_d = S_LAUNCH;
                    end
                end else if (cnt_q == TO_LAST) begin
                    err_evt    = 1'b1;
                    err_code_d = ERR_TIMEOUT;
                    state_d    = S_DRAIN;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DRAIN: begin
                if (fifo_cnt == '0) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (fifo_push && fifo_full && !fifo_pop) begin
            err_evt    = 1'b1;
            err_code_d = ERR_OVF;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            num_q       <= '0;
            cnt_q       <= '0;
            err_code_q  <= ERR_NONE;
            eng_start_q <= 1'b0;
            mode_q      <= '0;
            base_q      <= '0;
            for (int i = 0; i < MAX_LAYERS; i++) begin
                tbl_mode_q[i] <= '0;
                tbl_base_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            num_q       <= num_d;
            cnt_q       <= cnt_d;
            err_code_q  <= err_code_d;
            // Launch is registered, so descriptor and strobe appear together.
            eng_start_q <= (state_q == S_LAUNCH);
            if (state_q == S_LAUNCH) begin
                mode_q <= tbl_mode_q[idx_q];
                base_q <= tbl_base_q[idx_q];
            end
            if (cfg_we && state_q == S_IDLE) begin
                tbl_mode_q[cfg_idx] <= cfg_mode;
                tbl_base_q[cfg_idx] <= cfg_base;
            end
        end
    end

    sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (fifo_push),
        .wdata_i (eng_res),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    // Outputs are forced quiet while rst is held, not only after its edge.
    assign busy      = !rst && (state_q != S_IDLE);
    assign done      = !rst && (state_q == S_DONE);
    assign err       = !rst && err_evt;
    assign err_code  = rst ? ERR_NONE : err_code_q;
    assign eng_start = !rst && eng_start_q;
    assign eng_mode  = rst ? '0 : mode_q;
    assign eng_base  = rst ? '0 : base_q;
    assign res_valid = !rst && !fifo_empty;
    assign res_data  = fifo_rdata;
    assign mem_we    = host_we && !rst && (state_q == S_IDLE);
    assign mem_addr  = host_addr;
    assign mem_wdata = host_wdata;

endmodule

// File: doc/cnn_accel_shell.md
CNN_ACCEL_SHELL -- requirements
Module: cnn_accel_shell

Interface
REQ-001 Parameters (name, default, meaning):
- DATA_WIDTH, 8, result/memory data width.
- ADDR_WIDTH, 11, engine RAM address width.
- MODE_WIDTH, 3, layer mode code width.
- MAX_LAYERS, 8, descriptor table depth.
- FIFO_DEPTH, 16, result FIFO depth (power of 2).
- TIMEOUT, 65535, max cycles per layer.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 Ports (name, direction, width, meaning):
- clk, in, 1, clock.
- rst, in, 1, synchronous active-high reset.
- start, in, 1, launch job.
- num_layers, in, clog2(MAX_LAYERS)+1, layers in job; sampled on accepted start.
- cfg_we, in, 1, descriptor write.
- cfg_idx, in, clog2(MAX_LAYERS), descriptor index.
- cfg_mode, in, MODE_WIDTH, layer mode.
- cfg_base, in, ADDR_WIDTH, layer base address.
- host_we, in, 1, host RAM write.
- host_addr, in, ADDR_WIDTH, host RAM address.
- host_wdata, in, DATA_WIDTH, host RAM data.
- mem_we, out, 1, gated RAM write.
- mem_addr, out, ADDR_WIDTH, gated RAM address.
- mem_wdata, out, DATA_WIDTH, gated RAM data.
- eng_start, out, 1, engine start pulse.
- eng_mode, out, MODE_WIDTH, current layer mode.
- eng_base, out, ADDR_WIDTH, current layer base.
- eng_done, in, 1, engine layer complete.
- eng_res_valid, in, 1, engine result strobe.
- eng_res, in, DATA_WIDTH, engine result.
- res_valid, out, 1, result stream valid.
- res_ready, in, 1, result stream ready.
- res_data, out, DATA_WIDTH, result stream data.
- busy, out, 1, job in progress.
- done, out, 1, job complete pulse.
- err, out, 1, error pulse.
- err_code, out, 2, sticky cause: 0 none, 1 bad num_layers, 2 timeout, 3 FIFO overflow.

Function
REQ-004 FSM states SHALL be IDLE, LAUNCH, WAIT, DRAIN, DONE; busy=1 in every state except IDLE.
REQ-005 IDLE: start with 1<=num_layers<=MAX_LAYERS SHALL clear err_code, set layer_idx=0, go to LAUNCH; any other num_layers SHALL pulse err one cycle, set err_code=1, stay IDLE.
REQ-006 LAUNCH SHALL assert eng_start for exactly one cycle, with eng_mode/eng_base = table[layer_idx] held stable through WAIT, then go to WAIT and clear the timeout counter.
REQ-007 WAIT on eng_done: if layer_idx==num_layers-1 go to DRAIN, else increment layer_idx and go to LAUNCH (2-cycle gap between eng_done and the next eng_start).
REQ-008 WAIT SHALL count cycles; at count==TIMEOUT without eng_done it SHALL pulse err, set err_code=2, discard remaining layers, go to DRAIN.
REQ-009 eng_res_valid SHALL push eng_res into the FIFO only while in WAIT on the final layer; results of intermediate layers are ignored.
REQ-010 eng_res_valid and eng_done in the same cycle SHALL push the result before the transition.
REQ-011 A push into a full FIFO without a same-cycle pop SHALL drop the data, pulse err, set err_code=3; the job continues.
REQ-012 Push and pop in the same cycle on a full FIFO SHALL both succeed with count unchanged; there is no empty-FIFO bypass (data is visible the cycle after push).
REQ-013 res_valid SHALL equal FIFO non-empty; a pop occurs when res_valid&&res_ready; res_data SHALL be stable while res_valid&&!res_ready.
REQ-014 DRAIN SHALL wait for FIFO empty, then go to DONE; DONE SHALL pulse done for one cycle and return to IDLE.
REQ-015 mem_we SHALL equal host_we&&!busy, combinationally; mem_addr/mem_wdata SHALL pass host_addr/host_wdata straight through; host writes while busy are discarded.
REQ-016 cfg_we SHALL write the table only in IDLE; it is ignored while busy. start while busy SHALL be ignored.
REQ-017 err_code SHALL keep the last cause until the next accepted start or reset.

Reset
REQ-018 rst SHALL force IDLE, layer_idx=0, the FIFO to empty, and all descriptor entries to 0.
REQ-019 During rst, outputs SHALL be: busy, done, err, eng_start, res_valid, mem_we = 0; err_code=0; eng_mode, eng_base = 0.
REQ-020 rst asserted mid-job SHALL abort the job with no done pulse; engine-side cleanup is the system's responsibility.

Structure
REQ-021 The state encoding and err_code constants SHALL live in a shared package, cnn_accel_pkg.
REQ-022 The result FIFO SHALL be one sub-module, sync_fifo, parametrised by DATA_WIDTH and FIFO_DEPTH, with full/empty/count outputs.

Verification
REQ-023 Load 3 descriptors, num_layers=3, engine model returns done after 50 cycles per layer -> 3 eng_start pulses each carrying the matching mode/base; done pulses once after the final layer's results drain.
REQ-024 Final layer emits 20 results, res_ready=0 throughout -> 16 stored, err pulse with err_code=3; then res_ready=1 -> 16 results in order, then done.
REQ-025 start with num_layers=0, then with num_layers=9 -> err pulse and err_code=1 each time; busy stays 0.
REQ-026 TIMEOUT=100, engine never sends done -> err at cycle 100 of WAIT with err_code=2, then done.
REQ-027 host_we during busy, and cfg_we during busy -> mem_we=0 and the table is unchanged; in IDLE -> mem_we follows host_we in the same cycle.
REQ-028 rst asserted in WAIT with 5 results in the FIFO -> next cycle shows IDLE, res_valid=0, busy=0, no done pulse.
